// File: rtl/alu_seq_pkg.sv
// Shared encodings for the sequential ALU: FSM states and operation codes.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        S_OFF   = 2'b00,
        S_READY = 2'b01,
        S_RUN   = 2'b10,
        S_ERROR = 2'b11
    } state_e;

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_XOR   = 3'd2,
        OP_NOTA  = 3'd3,
        OP_ADD   = 3'd4,
        OP_SUB   = 3'd5,
        OP_MUL   = 3'd6,
        OP_PASSB = 3'd7
    } op_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Shift-add multiplier: one partial-product bit per edge, WIDTH edges after go.
module alu_seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               running_q, running_d;
    logic [2*WIDTH-1:0] step_sum;

    // The final step's sum is exposed directly so the consumer can capture
    // the full product on the same edge the last bit is folded in.
    assign step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done     = running_q && (cnt_q == LAST);
    assign product  = step_sum;

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        running_d = running_q;
        if (abort) begin
            running_d = 1'b0;
            cnt_d     = '0;
        end else if (go) begin
            acc_d     = '0;
            mcand_d   = {{WIDTH{1'b0}}, a};
            mplier_d  = b;
            cnt_d     = '0;
            running_d = 1'b1;
        end else if (running_q) begin
            acc_d    = step_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
                running_d = 1'b0;
                cnt_d     = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: synchronous reset: rst is just another input sampled on the edge.
        if (rst) begin
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop sees pre-edge values.
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            running_q <= running_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with accumulator feedback and an off/ready/run/error FSM.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             on,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             load_acc,
    input  logic [WIDTH-1:0] num_a,
    input  logic [WIDTH-1:0] num_b,
    input  logic             clear_err,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             error,
    output logic [1:0]       state
);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               overflow_q, overflow_d;
    logic               done_q, done_d;

    logic               accept;
    logic [WIDTH-1:0]   opnd_a;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;

    assign accept = on && (state_q == S_READY) && start;
    assign opnd_a = load_acc ? num_a : result_q;

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .go      (accept && (op_e'(op) == OP_MUL)),
        .abort   (!on),
        .a       (opnd_a),
        .b       (num_b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        sum_ext = {1'b0, a_q} + {1'b0, b_q};
        alu_res = '0;
        alu_ovf = 1'b0;
        unique case (op_q)
            OP_AND:   alu_res = a_q & b_q;
            OP_OR:    alu_res = a_q | b_q;
            OP_XOR:   alu_res = a_q ^ b_q;
            OP_NOTA:  alu_res = ~a_q;
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_ovf = sum_ext[WIDTH];
            end
            OP_SUB: begin
                alu_res = a_q - b_q;
                alu_ovf = (a_q < b_q);
            end
            OP_MUL: begin
                alu_res = mul_product[WIDTH-1:0];
                alu_ovf = |mul_product[2*WIDTH-1:WIDTH];
            end
            OP_PASSB: alu_res = b_q;
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        // Power-down wins over everything but rst and silently abandons a run.
        if (!on) begin
            state_d = S_OFF;
        end else begin
            unique case (state_q)
                S_OFF:   state_d = S_READY;
                S_READY: begin
                    if (start) begin
                        state_d = S_RUN;
                        op_d    = op_e'(op);
                        a_d     = opnd_a;
                        b_d     = num_b;
                    end
                end
                S_RUN: begin
                    if ((op_q != OP_MUL) || mul_done) begin
                        result_d   = alu_res;
                        overflow_d = alu_ovf;
                        done_d     = 1'b1;
                        state_d    = alu_ovf ? S_ERROR : S_READY;
                    end
                end
                S_ERROR: begin
                    if (clear_err) state_d = S_READY;
                end
                default: state_d = S_OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_OFF;
            op_q       <= OP_AND;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign ready    = (state_q == S_READY);
    assign busy     = (state_q == S_RUN);
    assign error    = (state_q == S_ERROR);
    assign done     = done_q;
    assign result   = result_q;
    assign overflow = overflow_q;
    assign state    = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed plan plus random ops against an arithmetic model.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit instance
    logic       rst, on, start, load_acc, clear_err;
    logic [2:0] op;
    logic [7:0] num_a, num_b, result;
    logic       ready, busy, done, overflow, error;
    logic [1:0] state;

    // 16-bit instance
    logic        rst16, on16, start16, la16, ce16;
    logic [2:0]  op16;
    logic [15:0] na16, nb16, result16;
    logic        ready16, busy16, done16, ovf16, error16;
    logic [1:0]  state16;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] model_result = 8'h00;
    bit         model_ovf = 1'b0;

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .on(on), .start(start), .op(op), .load_acc(load_acc),
        .num_a(num_a), .num_b(num_b), .clear_err(clear_err), .ready(ready), .busy(busy),
        .done(done), .result(result), .overflow(overflow), .error(error), .state(state)
    );

    alu_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst16), .on(on16), .start(start16), .op(op16), .load_acc(la16),
        .num_a(na16), .num_b(nb16), .clear_err(ce16), .ready(ready16), .busy(busy16),
        .done(done16), .result(result16), .overflow(ovf16), .error(error16), .state(state16)
    );

    // Reference: plain unsigned arithmetic modulo 2^w.
    function automatic void model_op(input int o, input longint unsigned a, input longint unsigned b,
                                     input int w, output longint unsigned res, output bit ovf);
        longint unsigned m = 64'd1 << w;
        ovf = 1'b0;
        res = 0;
        case (o)
            0: res = a & b;
            1: res = a | b;
            2: res = a ^ b;
            3: res = ~a & (m - 1);
            4: begin res = (a + b) % m; ovf = (a + b) >= m; end
            5: begin res = (a + m - b) % m; ovf = a < b; end
            6: begin res = (a * b) % m; ovf = (a * b) >= m; end
            default: res = b;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; on = 1'b1; start = 1'b0; clear_err = 1'b0;
        op = 3'd0; load_acc = 1'b0; num_a = 8'h00; num_b = 8'h00;
        step(); step();
        vectors++;
        if ({ready, busy, done, error, overflow, state, result} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rdy=%b bsy=%b dn=%b err=%b ovf=%b st=%b res=%h, want all 0",
                     ready, busy, done, error, overflow, state, result);
        end
        rst = 1'b0;
        step();
        vectors++;
        if (state !== S_READY) begin
            miscompares++;
            $display("FAIL reset_to_ready: state=%b want 01", state);
        end
        model_result = 8'h00;
        model_ovf = 1'b0;
    endtask

    task automatic do_op(input logic [2:0] o, input bit la, input logic [7:0] a, input logic [7:0] b);
        longint unsigned er;
        bit eo;
        int n, nbusy, lat;
        logic [7:0] ea;
        ea = la ? a : model_result;
        model_op(int'(o), longint'(ea), longint'(b), 8, er, eo);
        lat = (o == 3'd6) ? 8 : 1;
        vectors++;
        if (ready !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_accept_ready: ready=%b want 1 (op %0d)", ready, o);
        end
        start = 1'b1; op = o; load_acc = la; num_a = a; num_b = b;
        step();
        start = 1'b0; op = 3'($urandom); load_acc = 1'($urandom);
        num_a = 8'($urandom); num_b = 8'($urandom);
        vectors++;
        if ({busy, done, state} !== {1'b1, 1'b0, 2'b10}) begin
            miscompares++;
            $display("FAIL run_entry: busy=%b done=%b state=%b want 1 0 10", busy, done, state);
        end
        n = 0; nbusy = 0;
        while (done !== 1'b1 && n < 20) begin
            nbusy += int'(busy);
            start = 1'($urandom);  // ignored while running
            step();
            n++;
        end
        start = 1'b0;
        vectors++;
        if (n !== lat || nbusy !== lat) begin
            miscompares++;
            $display("FAIL latency op%0d: done after %0d edges busy %0d cycles, want %0d", o, n, nbusy, lat);
        end
        vectors++;
        if ({result, overflow, state, error, ready} !== {8'(er), eo, eo ? 2'b11 : 2'b01, eo, !eo}) begin
            miscompares++;
            $display("FAIL result op%0d A=%h B=%h: res=%h ovf=%b st=%b err=%b rdy=%b, want res=%h ovf=%b",
                     o, ea, b, result, overflow, state, error, ready, 8'(er), eo);
        end
        model_result = 8'(er);
        model_ovf = eo;
    endtask

    task automatic test_error_clear();
        start = 1'b1;
        step();
        vectors++;
        if ({state, busy, result} !== {2'b11, 1'b0, model_result}) begin
            miscompares++;
            $display("FAIL start_in_error: state=%b busy=%b res=%h, want 11 0 %h", state, busy, result, model_result);
        end
        clear_err = 1'b1;
        step();
        start = 1'b0; clear_err = 1'b0;
        vectors++;
        if ({state, busy, result, overflow} !== {2'b01, 1'b0, model_result, model_ovf}) begin
            miscompares++;
            $display("FAIL clear_err: state=%b busy=%b res=%h ovf=%b, want 01 0 %h %b",
                     state, busy, result, overflow, model_result, model_ovf);
        end
    endtask

    task automatic test_directed();
        do_op(3'd4, 1'b1, 8'h30, 8'h25);
        do_op(3'd4, 1'b0, 8'hFF, 8'hC0);
        test_error_clear();
        do_op(3'd6, 1'b1, 8'h0D, 8'h0B);
        do_op(3'd6, 1'b1, 8'h20, 8'h10);
        test_error_clear();
        do_op(3'd5, 1'b1, 8'h10, 8'h20);
        test_error_clear();
        do_op(3'd3, 1'b1, 8'h0F, 8'h77);
        do_op(3'd7, 1'b1, 8'h3C, 8'hA5);
    endtask

    task automatic test_back_to_back();
        do_op(3'd0, 1'b1, 8'hF3, 8'h5A);
        do_op(3'd1, 1'b0, 8'h00, 8'h81);
        do_op(3'd2, 1'b0, 8'h00, 8'hFF);
        do_op(3'd7, 1'b1, 8'h00, 8'h42);
    endtask

    task automatic test_abort_off();
        start = 1'b1; op = 3'd6; load_acc = 1'b1; num_a = 8'h0F; num_b = 8'h0E;
        step();
        start = 1'b0;
        step(); step();
        on = 1'b0;
        step();
        vectors++;
        if ({state, done, result, overflow} !== {2'b00, 1'b0, model_result, model_ovf}) begin
            miscompares++;
            $display("FAIL abort_off: state=%b done=%b res=%h ovf=%b, want 00 0 %h %b",
                     state, done, result, overflow, model_result, model_ovf);
        end
        step();
        vectors++;
        if ({state, done} !== {2'b00, 1'b0}) begin
            miscompares++;
            $display("FAIL stay_off: state=%b done=%b, want 00 0", state, done);
        end
        on = 1'b1;
        step();
        vectors++;
        if (state !== S_READY) begin
            miscompares++;
            $display("FAIL power_up: state=%b want 01", state);
        end
        do_op(3'd6, 1'b1, 8'h07, 8'h09);
    endtask

    task automatic test_abort_rst();
        start = 1'b1; op = 3'd6; load_acc = 1'b1; num_a = 8'h05; num_b = 8'h06;
        step();
        start = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        vectors++;
        if ({state, done, result, overflow} !== {2'b00, 1'b0, 8'h00, 1'b0}) begin
            miscompares++;
            $display("FAIL rst_mid_mul: state=%b done=%b res=%h ovf=%b, want 00 0 00 0",
                     state, done, result, overflow);
        end
        rst = 1'b0;
        model_result = 8'h00;
        model_ovf = 1'b0;
        step();
        do_op(3'd6, 1'b1, 8'h03, 8'h05);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            if (state === S_ERROR) test_error_clear();
            do_op(3'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
        end
    endtask

    task automatic do_op16(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
        longint unsigned er;
        bit eo;
        int n, lat;
        model_op(int'(o), longint'(a), longint'(b), 16, er, eo);
        lat = (o == 3'd6) ? 16 : 1;
        start16 = 1'b1; op16 = o; la16 = 1'b1; na16 = a; nb16 = b;
        step();
        start16 = 1'b0;
        n = 0;
        while (done16 !== 1'b1 && n < 30) begin
            vectors++;
            if (busy16 !== 1'b1) begin
                miscompares++;
                $display("FAIL w16_busy: busy=%b at run cycle %0d", busy16, n);
            end
            step();
            n++;
        end
        vectors++;
        if (n !== lat || {result16, ovf16, state16} !== {16'(er), eo, eo ? 2'b11 : 2'b01}) begin
            miscompares++;
            $display("FAIL w16_op%0d: edges=%0d res=%h ovf=%b st=%b, want edges=%0d res=%h ovf=%b",
                     o, n, result16, ovf16, state16, lat, 16'(er), eo);
        end
        if (state16 === S_ERROR) begin
            ce16 = 1'b1;
            step();
            ce16 = 1'b0;
        end
    endtask

    task automatic test_width16();
        rst16 = 1'b1; on16 = 1'b1; start16 = 1'b0; ce16 = 1'b0;
        op16 = 3'd0; la16 = 1'b0; na16 = 16'h0; nb16 = 16'h0;
        step(); step();
        rst16 = 1'b0;
        step();
        do_op16(3'd6, 16'h0100, 16'h00FF);
        do_op16(3'd4, 16'hFFFF, 16'h0001);
        do_op16(3'd6, 16'h1234, 16'h0100);
        for (int i = 0; i < 4; i++) do_op16(3'($urandom), 16'($urandom), 16'($urandom));
    endtask

    initial begin
        rst16 = 1'b1; on16 = 1'b0; start16 = 1'b0; ce16 = 1'b0;
        op16 = 3'd0; la16 = 1'b0; na16 = 16'h0; nb16 = 16'h0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_abort_off();
        test_abort_rst();
        test_random();
        test_width16();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential ALU with an accumulator and an operating-state FSM (off / ready / run / error). It latches operands on a start handshake and executes one of eight operations. Logic, add and sub complete in one cycle; multiply is a shift-add over WIDTH cycles. Arithmetic overflow parks the block in an error state until it is explicitly cleared. It replaces the fixed 8-bit, one-hot-select ALU datapath and sits between the operand sources and the result consumer.

## Interface
- WIDTH, 8: operand, accumulator and result width (≥ 2)
- clk  in  1  single clock, all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- on  in  1  power enable; low forces S_OFF
- start  in  1  request an operation; accepted only when ready=1
- op  in  3  operation code, sampled on accept
- load_acc  in  1  on accept: 1 = A from num_a, 0 = A from current result
- num_a  in  WIDTH  operand A source
- num_b  in  WIDTH  operand B
- clear_err  in  1  leave S_ERROR
- ready  out  1  state==S_READY
- busy  out  1  state==S_RUN
- done  out  1  one-cycle pulse, result just updated
- result  out  WIDTH  registered accumulator/result
- overflow  out  1  overflow flag of last completed op (registered)
- error  out  1  state==S_ERROR
- state  out  2  current FSM state

## Operation
- States: S_OFF=2'b00, S_READY=2'b01, S_RUN=2'b10, S_ERROR=2'b11.
- Transitions:
  - S_OFF→S_READY when on=1.
  - S_READY→S_RUN on start=1. Operands and op are latched: A=(load_acc ? num_a : result), B=num_b.
  - S_RUN→S_ERROR if the completing op overflows, else S_RUN→S_READY.
  - S_ERROR→S_READY on clear_err=1.
  - on=0 in any state→S_OFF; this has priority over every transition except rst.
- Op codes:
  - 0 AND, 1 OR, 2 XOR, 3 NOT A, 4 ADD, 5 SUB (A−B), 6 MUL, 7 PASS B.
- Overflow rules:
  - ADD: carry out of bit WIDTH-1.
  - SUB: borrow (A<B unsigned).
  - MUL: any nonzero bit in product[2W-1:W].
  - All others: 0.
- result = low WIDTH bits of the outcome. All arithmetic is unsigned, modulo 2^WIDTH.
- result and overflow update only on completion. They hold through S_READY, S_ERROR and S_OFF.
- start outside S_READY is ignored and not queued. Other inputs are don't-care outside the accept cycle.
- on=0 mid-run aborts the run: no done, result and overflow unchanged, multiplier counter cleared.
- clear_err and start together in S_ERROR: clear only, start is ignored.
- rst: state=S_OFF, result=0, overflow=0, done=0, internal counter/product=0. Hence ready=0, busy=0, error=0, state=2'b00. With on=1 the block reaches S_READY one edge after rst deasserts.

## Timing
- Accept at edge k (state S_READY, start=1).
- Ops 0–5 and 7: computed in S_RUN; result, overflow and done=1 are visible after edge k+1.
- MUL: one partial-product bit per edge over edges k+1..k+WIDTH. done is visible after edge k+WIDTH. busy is high for exactly WIDTH cycles.
- done is high for exactly one cycle. ready is already 1 in that same cycle if no overflow occurred, so back-to-back starts give one op per 2 cycles (non-MUL).
- No combinational path from inputs to any output.

## Structure
- Package alu_seq_pkg holds the state encodings (S_OFF..S_ERROR) and the op code constants (OP_AND..OP_PASSB). The bench imports it too.
- Sub-module alu_seq_mul: WIDTH-parameterised shift-add multiplier.
  - Ports: clk, rst, go, abort, a, b, done, product[2*WIDTH-1:0].
  - Internal counter of $clog2(WIDTH+1) bits.
- Single-cycle ops and the FSM live in alu_seq.

## Test plan
- rst=1 for 2 cycles with on=1, then release → all outputs 0, state=00, then state=01 after the next edge.
- ADD, load_acc=1, num_a=8'h30, num_b=8'h25 → done one edge after accept, result=8'h55, overflow=0, state back to 01.
- Chained ADD, load_acc=0, num_b=8'hC0 → result=8'h15, overflow=1, state=11, error=1. A start while in error is ignored. clear_err → state=01, result still 8'h15.
- MUL with 8'h0D × 8'h0B → busy exactly 8 cycles, result=8'h8F, overflow=0. Then MUL with 8'h20 × 8'h10 → result=8'h00, overflow=1, state=11.
- SUB 8'h10−8'h20 → result=8'hF0, overflow=1. NOT with num_a=8'h0F → result=8'hF0, overflow=0. PASS B 8'hA5 → 8'hA5.
- Abort cases:
  - on=0 on the 3rd cycle of a MUL → state=00 next edge, no done, result unchanged.
  - rst mid-MUL → result=0, state=00.
  - Repeat with WIDTH=16: 16'h0100 × 16'h00FF → 16'hFF00 after 16 cycles.
